// File: rtl/decode_pkg.sv
// Shared decode types: opcodes, immediate formats, operations, control bundle and the buffered entry.
package decode_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} format_t;

  typedef enum logic [2:0] {BC_NONE, BC_EQ, BC_NE, BC_LT, BC_GE, BC_LTU, BC_GEU} branch_condition_t;

  // Register and immediate ALU groups are ordered by funct3 so they can be indexed directly.
  typedef enum logic [5:0] {
    OPER_NONE,
    OPER_ADD, OPER_SLL, OPER_SLT, OPER_SLTU, OPER_XOR, OPER_SRL, OPER_OR, OPER_AND,
    OPER_SUB, OPER_SRA,
    OPER_ADDI, OPER_SLLI, OPER_SLTI, OPER_SLTIU, OPER_XORI, OPER_SRLI, OPER_ORI, OPER_ANDI,
    OPER_SRAI,
    OPER_LUI, OPER_AUIPC, OPER_JAL, OPER_JALR, OPER_BRANCH,
    OPER_LB, OPER_LH, OPER_LW, OPER_LBU, OPER_LHU,
    OPER_SB, OPER_SH, OPER_SW,
    OPER_MUL, OPER_MULH, OPER_MULHSU, OPER_MULHU, OPER_DIV, OPER_DIVU, OPER_REM, OPER_REMU,
    OPER_FENCE, OPER_ECALL, OPER_EBREAK
  } operation_t;

  typedef struct packed {
    logic register_write_enable;
    logic memory_read_enable;
    logic memory_write_enable;
    logic branch;
    logic jump;
    logic alu_use_immediate;
    logic alu_use_pc;
  } control_t;

  // Immediate is sign-extended and pc zero-extended to XLEN_MAX so one type serves both XLENs.
  typedef struct packed {
    control_t                control;
    operation_t              operation;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [XLEN_MAX-1:0]     immediate;
    logic [XLEN_MAX-1:0]     program_counter;
    branch_condition_t       branch_condition;
    logic                    illegal;
  } decoded_t;

  function automatic format_t opcode_format(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: return FMT_I;
      OPC_STORE:                                                return FMT_S;
      OPC_BRANCH:                                               return FMT_B;
      OPC_LUI, OPC_AUIPC:                                       return FMT_U;
      OPC_JAL:                                                  return FMT_J;
      default:                                                  return FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_immediate_generator.sv
// Combinational immediate extraction for I/S/B/U/J formats, sign-extended from bit 31 to XLEN.
module immediate_generator
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (opcode_format(instruction[6:0]))
      FMT_I:   imm32 = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S:   imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:   imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
      FMT_U:   imm32 = {instruction[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                        instruction[20], instruction[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32 decoder feeding a DEPTH-entry circular buffer; decode happens at push, outputs come from flops.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned DEPTH           = 2,
  parameter bit          ENABLE_MULTIPLY = 1'b0,
  parameter bit          ENABLE_SYSTEM   = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction,
  input  logic [XLEN-1:0]            program_counter,
  output logic                       out_valid,
  input  logic                       out_ready,
  output decoded_t                   decoded,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm_value;
  control_t          ctrl;
  operation_t        oper;
  branch_condition_t bcond;
  logic              legal;
  decoded_t          entry;
  logic              push, pop;

  decoded_t          buffer_q [DEPTH];
  decoded_t          buffer_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  decoded_t          decoded_q, decoded_d;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  immediate_generator #(.XLEN(XLEN)) u_immediate_generator (
    .instruction (instruction),
    .immediate   (imm_value)
  );

  // Instruction classification; anything not explicitly legal collapses to a zeroed illegal entry.
  always_comb begin
    ctrl  = '0;
    oper  = OPER_NONE;
    bcond = BC_NONE;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.register_write_enable = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          oper  = operation_t'(6'(OPER_ADD) + 6'(funct3));
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal = 1'b1;
          oper  = (funct3 == 3'b000) ? OPER_SUB : OPER_SRA;
        end else if (ENABLE_MULTIPLY && funct7 == 7'b0000001) begin
          legal = 1'b1;
          oper  = operation_t'(6'(OPER_MUL) + 6'(funct3));
        end
      end
      OPC_OP_IMM: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.alu_use_immediate     = 1'b1;
        legal = 1'b1;
        oper  = operation_t'(6'(OPER_ADDI) + 6'(funct3));
        if (funct3 == 3'b001) begin
          legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          if (funct7[5]) oper = OPER_SRAI;
        end
      end
      OPC_LOAD: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.memory_read_enable    = 1'b1;
        ctrl.alu_use_immediate     = 1'b1;
        legal = 1'b1;
        case (funct3)
          3'b000:  oper = OPER_LB;
          3'b001:  oper = OPER_LH;
          3'b010:  oper = OPER_LW;
          3'b100:  oper = OPER_LBU;
          3'b101:  oper = OPER_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        ctrl.memory_write_enable = 1'b1;
        ctrl.alu_use_immediate   = 1'b1;
        legal = 1'b1;
        case (funct3)
          3'b000:  oper = OPER_SB;
          3'b001:  oper = OPER_SH;
          3'b010:  oper = OPER_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        legal = 1'b1;
        oper  = OPER_BRANCH;
        case (funct3)
          3'b000:  bcond = BC_EQ;
          3'b001:  bcond = BC_NE;
          3'b100:  bcond = BC_LT;
          3'b101:  bcond = BC_GE;
          3'b110:  bcond = BC_LTU;
          3'b111:  bcond = BC_GEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_JAL: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.jump                  = 1'b1;
        ctrl.alu_use_pc            = 1'b1;
        legal = 1'b1;
        oper  = OPER_JAL;
      end
      OPC_JALR: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.jump                  = 1'b1;
        ctrl.alu_use_immediate     = 1'b1;
        legal = 1'b1;
        oper  = OPER_JALR;
      end
      OPC_LUI: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.alu_use_immediate     = 1'b1;
        legal = 1'b1;
        oper  = OPER_LUI;
      end
      OPC_AUIPC: begin
        ctrl.register_write_enable = 1'b1;
        ctrl.alu_use_immediate     = 1'b1;
        ctrl.alu_use_pc            = 1'b1;
        legal = 1'b1;
        oper  = OPER_AUIPC;
      end
      OPC_MISC_MEM: begin
        legal = ENABLE_SYSTEM && (funct3 == 3'b000);
        oper  = OPER_FENCE;
      end
      OPC_SYSTEM: begin
        if (ENABLE_SYSTEM && instruction[31:7] == 25'h0000000) begin
          legal = 1'b1;
          oper  = OPER_ECALL;
        end else if (ENABLE_SYSTEM && instruction[31:7] == 25'h0002000) begin
          legal = 1'b1;
          oper  = OPER_EBREAK;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl  = '0;
      oper  = OPER_NONE;
      bcond = BC_NONE;
    end
  end

  always_comb begin
    entry                  = '0;
    entry.control          = ctrl;
    entry.operation        = oper;
    entry.rs1              = instruction[19:15];
    entry.rs2              = instruction[24:20];
    entry.rd               = instruction[11:7];
    entry.immediate        = XLEN_MAX'($signed(imm_value));
    entry.program_counter  = XLEN_MAX'(program_counter);
    entry.branch_condition = bcond;
    entry.illegal          = !legal;
  end

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // The next head is either the entry being pushed (buffer empty or draining to it) or a stored entry.
  always_comb begin
    buffer_d  = buffer_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    decoded_d = decoded_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      decoded_d = '0;
    end else begin
      if (push) begin
        buffer_d[wr_ptr_q] = entry;
        wr_ptr_d           = ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_next(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (count_d == '0)                                     decoded_d = '0;
      else if (count_q == '0 || (pop && count_q == CNT_W'(1))) decoded_d = entry;
      else                                                   decoded_d = buffer_q[rd_ptr_d];
    end
    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      decoded_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      decoded_q   <= decoded_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    buffer_q <= buffer_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign decoded   = decoded_q;
  assign count     = count_q;

endmodule
